// File: rtl/traffic_pkg.sv
// Shared encodings and defaults for the traffic-light controller and the
// side-road CAR requester.
package traffic_pkg;

    localparam logic [1:0] REQ_IDLE    = 2'd0;
    localparam logic [1:0] REQ_REQUEST = 2'd1;
    localparam logic [1:0] REQ_SERVED  = 2'd2;
    localparam logic [1:0] REQ_HOLDOFF = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = REQ_IDLE,
        ST_REQUEST = REQ_REQUEST,
        ST_SERVED  = REQ_SERVED,
        ST_HOLDOFF = REQ_HOLDOFF
    } req_state_t;

    localparam logic [1:0] LC_GREEN  = 2'd0;
    localparam logic [1:0] LC_YELLOW = 2'd1;
    localparam logic [1:0] LC_RED    = 2'd2;

    localparam int DEF_DEB_CYCLES     = 4;
    localparam int DEF_HOLDOFF_CYCLES = 16;
    localparam int DEF_REQ_TIMEOUT    = 32768;
    localparam int DEF_PEND_W         = 4;

    // Exactly one lamp lit: odd parity excluding the all-on case.
    function automatic logic lights_onehot(input logic grn, input logic ylw, input logic red);
        return (grn ^ ylw ^ red) && !(grn && ylw && red);
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser plus saturating debounce counter; emits one arrival
// pulse per sufficiently long high episode of the loop detector.
module sensor_debounce
    import traffic_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic Clock,
    input  logic Reset,
    input  logic sensor,
    output logic arrival
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] deb_cnt;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            deb_cnt <= '0;
        end else begin
            sync1 <= sensor;
            sync2 <= sync1;
            if (!sync2) begin
                deb_cnt <= '0;
            end else if (deb_cnt != CNT_MAX) begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    // High on the edge where the counter steps onto DEB_CYCLES, so only once
    // per episode: afterwards the counter sits saturated.
    assign arrival = sync2 && (deb_cnt == CNT_LAST);

endmodule

// File: rtl/car_request_detector.sv
// Side-road requester: raises CAR on debounced arrivals, drops it when the
// controller leaves green, and waits a hold-off after green returns.
module car_request_detector
    import traffic_pkg::*;
#(
    parameter int DEB_CYCLES     = DEF_DEB_CYCLES,
    parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
    parameter int REQ_TIMEOUT    = DEF_REQ_TIMEOUT,
    parameter int PEND_W         = DEF_PEND_W
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              SENSOR,
    input  logic              GRN,
    input  logic              YLW,
    input  logic              RED,
    output logic              CAR,
    output logic [PEND_W-1:0] PENDING,
    output logic              FAULT
);

    localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
    localparam int WW = $clog2(REQ_TIMEOUT + 1);
    localparam logic [HW-1:0]     HOLD_LAST = HW'(HOLDOFF_CYCLES - 1);
    localparam logic [WW-1:0]     WAIT_MAX  = WW'(REQ_TIMEOUT);
    localparam logic [WW-1:0]     WAIT_LAST = WW'(REQ_TIMEOUT - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = '1;

    req_state_t        state;
    req_state_t        state_next;
    logic [PEND_W-1:0] pend_next;
    logic [PEND_W-1:0] pend_inc;
    logic [PEND_W-1:0] pend_arr;
    logic [HW-1:0]     hold_tmr;
    logic [HW-1:0]     hold_next;
    logic [WW-1:0]     wait_tmr;
    logic [WW-1:0]     wait_next;
    logic              fault_next;
    logic              arrival;

    sensor_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_debounce (
        .Clock  (Clock),
        .Reset  (Reset),
        .sensor (SENSOR),
        .arrival(arrival)
    );

    assign pend_inc = (PENDING == PEND_MAX) ? PENDING : PENDING + 1'b1;
    assign pend_arr = arrival ? pend_inc : PENDING;

    always_comb begin
        state_next = state;
        pend_next  = PENDING;
        hold_next  = '0;
        wait_next  = '0;
        fault_next = FAULT | !lights_onehot(GRN, YLW, RED);
        case (state)
            ST_IDLE: begin
                if (arrival) begin
                    state_next = ST_REQUEST;
                    pend_next  = PEND_W'(1);
                end
            end
            ST_REQUEST: begin
                if (wait_tmr == WAIT_LAST) fault_next = 1'b1;
                // Acknowledge wins over a same-edge arrival: that car is served.
                if (YLW || RED) begin
                    state_next = ST_SERVED;
                    pend_next  = '0;
                end else begin
                    wait_next = (wait_tmr == WAIT_MAX) ? wait_tmr : wait_tmr + 1'b1;
                    pend_next = pend_arr;
                end
            end
            ST_SERVED: begin
                if (GRN) state_next = ST_HOLDOFF;
            end
            ST_HOLDOFF: begin
                pend_next = pend_arr;
                if (hold_tmr == HOLD_LAST) begin
                    state_next = (pend_arr != '0) ? ST_REQUEST : ST_IDLE;
                end else begin
                    hold_next = hold_tmr + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                pend_next  = '0;
            end
        endcase
    end

    // CAR has its own flop so the request line never sees decode glitches.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= ST_IDLE;
            PENDING  <= '0;
            hold_tmr <= '0;
            wait_tmr <= '0;
            FAULT    <= 1'b0;
            CAR      <= 1'b0;
        end else begin
            state    <= state_next;
            PENDING  <= pend_next;
            hold_tmr <= hold_next;
            wait_tmr <= wait_next;
            FAULT    <= fault_next;
            CAR      <= (state_next == ST_REQUEST);
        end
    end

endmodule

// File: tb/tb_car_request_detector.sv
// Directed and randomized checks of car_request_detector against a
// cycle-indexed behavioural model.
module tb_car_request_detector;
    import traffic_pkg::*;

    localparam int D    = 4;
    localparam int H    = 16;
    localparam int TO   = 100;
    localparam int PW   = 4;
    localparam int PMAX = (1 << PW) - 1;

    localparam int P_IDLE = 0;
    localparam int P_REQ  = 1;
    localparam int P_SERV = 2;
    localparam int P_HOLD = 3;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          SENSOR;
    logic          GRN;
    logic          YLW;
    logic          RED;
    logic          CAR;
    logic [PW-1:0] PENDING;
    logic          FAULT;

    int n_assert = 0;
    int n_fail   = 0;

    car_request_detector #(
        .DEB_CYCLES    (D),
        .HOLDOFF_CYCLES(H),
        .REQ_TIMEOUT   (TO),
        .PEND_W        (PW)
    ) dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .SENSOR (SENSOR),
        .GRN    (GRN),
        .YLW    (YLW),
        .RED    (RED),
        .CAR    (CAR),
        .PENDING(PENDING),
        .FAULT  (FAULT)
    );

    always #5 Clock = ~Clock;

    // Model: sensor samples indexed by edge number, deadlines as edge numbers.
    bit sq[$];
    int cyc       = 0;
    int m_phase   = P_IDLE;
    int m_pend    = 0;
    bit m_fault   = 1'b0;
    bit m_car     = 1'b0;
    int req_since = 0;
    int hold_exit = 0;

    function automatic bit model_arrival();
        int n;
        n = sq.size() - 1;
        if (n - 1 - D < 0) return 1'b0;
        for (int k = n - 1 - D; k <= n - 2; k++) if (!sq[k]) return 1'b0;
        if (n - 2 - D >= 0 && sq[n - 2 - D]) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge Clock) begin
        bit arr;
        cyc++;
        if (Reset) begin
            sq.push_back(1'b0);
            if (sq.size() >= 2) sq[sq.size() - 2] = 1'b0;
            m_phase = P_IDLE;
            m_pend  = 0;
            m_fault = 1'b0;
        end else begin
            sq.push_back(SENSOR);
            arr = model_arrival();
            if (int'(GRN) + int'(YLW) + int'(RED) != 1) m_fault = 1'b1;
            case (m_phase)
                P_IDLE: if (arr) begin
                    m_phase = P_REQ; m_pend = 1; req_since = cyc;
                end
                P_REQ: begin
                    if (cyc - req_since == TO) m_fault = 1'b1;
                    if (YLW || RED) begin
                        m_phase = P_SERV; m_pend = 0;
                    end else if (arr && m_pend < PMAX) begin
                        m_pend++;
                    end
                end
                P_SERV: if (GRN) begin
                    m_phase = P_HOLD; hold_exit = cyc + H;
                end
                default: begin
                    if (arr && m_pend < PMAX) m_pend++;
                    if (cyc == hold_exit) begin
                        if (m_pend > 0) begin m_phase = P_REQ; req_since = cyc; end
                        else m_phase = P_IDLE;
                    end
                end
            endcase
        end
        m_car = (m_phase == P_REQ);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at time %0t", tag, obs, expv, $time);
        end
    endtask

    // Advance n edges, comparing against the model after each one.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clock);
            chk("car", 32'(CAR), 32'(m_car));
            chk("pending", 32'(PENDING), 32'(m_pend));
            chk("fault", 32'(FAULT), 32'(m_fault));
        end
    endtask

    task automatic chk_state(input string tag, input logic [1:0] expv);
        logic [1:0] st;
        st = dut.state;
        chk(tag, 32'(st), 32'(expv));
    endtask

    initial begin
        int s_left;
        int l_left;
        int r;
        Reset = 1'b1; SENSOR = 1'b0; GRN = 1'b1; YLW = 1'b0; RED = 1'b0;
        step(3);
        chk_state("reset_state", REQ_IDLE);
        Reset = 1'b0;
        step(50);
        chk("idle_car", 32'(CAR), 32'd0);
        chk_state("idle_state", REQ_IDLE);

        // Short and bouncy pulses must not register.
        SENSOR = 1'b1; step(3); SENSOR = 1'b0; step(6);
        chk("short_pulse_pend", 32'(PENDING), 32'd0);
        repeat (5) begin SENSOR = 1'b1; step(1); SENSOR = 1'b0; step(1); end
        step(4);
        chk("bouncy_car", 32'(CAR), 32'd0);

        // Debounced arrival latency, then accumulate three cars.
        SENSOR = 1'b1; step(6);
        chk("first_car", 32'(CAR), 32'd1);
        chk("first_pend", 32'(PENDING), 32'd1);
        SENSOR = 1'b0; step(3);
        repeat (2) begin SENSOR = 1'b1; step(6); SENSOR = 1'b0; step(3); end
        chk("three_pend", 32'(PENDING), 32'd3);
        GRN = 1'b0; YLW = 1'b1; step(1);
        chk("ack_car", 32'(CAR), 32'd0);
        chk("ack_pend", 32'(PENDING), 32'd0);
        step(2);
        YLW = 1'b0; RED = 1'b1; step(3);
        RED = 1'b0; GRN = 1'b1; step(16);
        chk("holdoff_car", 32'(CAR), 32'd0);
        step(1);
        chk_state("holdoff_to_idle", REQ_IDLE);

        // Arrival while served is dropped; arrival in hold-off re-requests at exit.
        SENSOR = 1'b1; step(6); SENSOR = 1'b0;
        GRN = 1'b0; RED = 1'b1; step(1);
        SENSOR = 1'b1; step(6); SENSOR = 1'b0; step(3);
        chk("served_drop_pend", 32'(PENDING), 32'd0);
        RED = 1'b0; GRN = 1'b1; step(1);
        SENSOR = 1'b1; step(6);
        chk("holdoff_arr_pend", 32'(PENDING), 32'd1);
        chk("holdoff_arr_car", 32'(CAR), 32'd0);
        SENSOR = 1'b0; step(9);
        chk("pre_exit_car", 32'(CAR), 32'd0);
        step(1);
        chk("exit_car", 32'(CAR), 32'd1);

        // Unacknowledged request times out; FAULT sticky until Reset.
        step(99);
        chk("pre_timeout_fault", 32'(FAULT), 32'd0);
        step(1);
        chk("timeout_fault", 32'(FAULT), 32'd1);
        chk("timeout_car", 32'(CAR), 32'd1);
        GRN = 1'b0; YLW = 1'b1; step(2);
        chk("sticky_fault", 32'(FAULT), 32'd1);
        Reset = 1'b1; step(1);
        chk("reset_fault", 32'(FAULT), 32'd0);
        Reset = 1'b0; YLW = 1'b0; GRN = 1'b1; step(2);
        RED = 1'b1; step(1);
        chk("lights_fault", 32'(FAULT), 32'd1);
        RED = 1'b0; step(5);
        chk("lights_fault_sticky", 32'(FAULT), 32'd1);
        Reset = 1'b1; step(1);
        Reset = 1'b0;

        // Reset in REQUEST with five cars waiting, sensor held through reset.
        repeat (4) begin SENSOR = 1'b1; step(6); SENSOR = 1'b0; step(3); end
        SENSOR = 1'b1; step(6);
        chk("five_pend", 32'(PENDING), 32'd5);
        Reset = 1'b1; step(1);
        chk("mid_reset_car", 32'(CAR), 32'd0);
        chk("mid_reset_pend", 32'(PENDING), 32'd0);
        chk_state("mid_reset_state", REQ_IDLE);
        Reset = 1'b0; step(5);
        chk("rearm_early_car", 32'(CAR), 32'd0);
        step(1);
        chk("rearm_car", 32'(CAR), 32'd1);
        SENSOR = 1'b0; step(3);

        // Randomized traffic against the model.
        s_left = 0;
        l_left = 0;
        for (int i = 0; i < 4000; i++) begin
            if (s_left == 0) begin
                SENSOR = ~SENSOR;
                s_left = SENSOR ? $urandom_range(1, 9) : $urandom_range(1, 6);
            end
            s_left--;
            if (l_left == 0) begin
                r = $urandom_range(0, 19);
                if (r == 0) {GRN, YLW, RED} = 3'($urandom_range(0, 7));
                else {GRN, YLW, RED} = (r % 3 == 0) ? 3'b100 : (r % 3 == 1) ? 3'b010 : 3'b001;
                l_left = $urandom_range(1, 120);
            end
            l_left--;
            Reset = ($urandom_range(0, 499) == 0);
            step(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
